// File: rtl/wbu_busguard.sv
// Wishbone pipelined bus guard. It passes master/slave traffic through with
// zero added latency, limits the number of outstanding requests, and aborts
// a hung transaction upstream with an error when the watchdog expires.
module wbu_busguard #(
  parameter int AW         = 30,
  parameter int DW         = 32,
  parameter int LGWATCHDOG = 19,
  parameter int LGOUTST    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [LGWATCHDOG-1:0] i_timeout,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_stb,
  input  logic                  i_wb_we,
  input  logic [AW-1:0]         i_wb_addr,
  input  logic [DW-1:0]         i_wb_data,
  input  logic [DW/8-1:0]       i_wb_sel,
  output logic                  o_wb_stall,
  output logic                  o_wb_ack,
  output logic                  o_wb_err,
  output logic [DW-1:0]         o_wb_data,
  output logic                  o_s_cyc,
  output logic                  o_s_stb,
  output logic                  o_s_we,
  output logic [AW-1:0]         o_s_addr,
  output logic [DW-1:0]         o_s_data,
  output logic [DW/8-1:0]       o_s_sel,
  input  logic                  i_s_stall,
  input  logic                  i_s_ack,
  input  logic                  i_s_err,
  input  logic [DW-1:0]         i_s_data,
  output logic                  o_timeout,
  output logic [15:0]           o_abort_count,
  output logic [LGOUTST:0]      o_outstanding
);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT, DRAIN} state_t;

  localparam logic [LGOUTST:0] FULL_CNT = {1'b1, {LGOUTST{1'b0}}};

  state_t                state, state_nx;
  logic [LGWATCHDOG-1:0] timer;
  logic [LGOUTST:0]      outst;
  logic [15:0]           abort_cnt;
  logic                  pass, full, accept, response, fire;

  assign pass     = (state == IDLE) || (state == BUSY);
  assign full     = (outst == FULL_CNT);
  assign accept   = o_s_stb && !i_s_stall;
  assign response = i_s_ack || i_s_err;
  // Any bus progress on the expiry cycle wins over the abort.
  assign fire     = (state == BUSY) && i_wb_cyc && (i_timeout != '0)
                    && (timer == i_timeout - LGWATCHDOG'(1))
                    && !accept && !response;

  assign o_s_we        = i_wb_we;
  assign o_s_addr      = i_wb_addr;
  assign o_s_data      = i_wb_data;
  assign o_s_sel       = i_wb_sel;
  assign o_wb_data     = i_s_data;
  assign o_outstanding = outst;
  assign o_abort_count = abort_cnt;

  // Next state and bus-facing outputs; reset drops the downstream cycle immediately.
  always_comb begin
    state_nx   = state;
    o_s_cyc    = 1'b0;
    o_s_stb    = 1'b0;
    o_wb_stall = 1'b1;
    o_wb_ack   = 1'b0;
    o_wb_err   = 1'b0;
    o_timeout  = 1'b0;
    case (state)
      IDLE, BUSY: begin
        o_s_cyc    = i_wb_cyc && !i_reset;
        o_s_stb    = i_wb_stb && !full && !i_reset;
        o_wb_stall = i_s_stall || full;
        o_wb_err   = i_s_err && !i_reset;
        o_wb_ack   = i_s_ack && !i_s_err && !i_reset;
        if (state == IDLE) begin
          if (i_wb_cyc) state_nx = BUSY;
        end else if (!i_wb_cyc) begin
          state_nx = IDLE;
        end else if (fire) begin
          state_nx = ABORT;
        end
      end
      ABORT: begin
        o_wb_err  = !i_reset;
        o_timeout = 1'b1;
        state_nx  = DRAIN;
      end
      DRAIN: begin
        if (!i_wb_cyc) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  // Outstanding-request counter; forced to zero outside a live passthrough cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset || !pass || !i_wb_cyc || fire)
      outst <= '0;
    else if (accept && !response)
      outst <= outst + (LGOUTST+1)'(1);
    else if (!accept && response && (outst != '0))
      outst <= outst - (LGOUTST+1)'(1);
  end

  // Watchdog timer. While disabled (i_timeout==0) it holds rather than clears,
  // so re-enabling starts the count from the last bus activity.
  always_ff @(posedge i_clk) begin
    if (i_reset || (state != BUSY) || !i_wb_cyc || accept || response || fire)
      timer <= '0;
    else if ((i_timeout != '0) && ((outst != '0) || i_wb_stb))
      timer <= timer + LGWATCHDOG'(1);
  end

  // Saturating abort counter.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      abort_cnt <= '0;
    else if (fire && (abort_cnt != '1))
      abort_cnt <= abort_cnt + 16'd1;
  end

endmodule

// File: tb/tb_wbu_busguard.sv
// Bench for wbu_busguard: directed scenarios plus randomized traffic, every
// cycle compared against a transaction-level model of the guard's rules.
module tb_wbu_busguard;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LGW = 19;
  localparam int LGO = 2;
  localparam int CAP = 4;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic [LGW-1:0]  i_timeout;
  logic            i_wb_cyc, i_wb_stb, i_wb_we;
  logic [AW-1:0]   i_wb_addr;
  logic [DW-1:0]   i_wb_data;
  logic [DW/8-1:0] i_wb_sel;
  logic            o_wb_stall, o_wb_ack, o_wb_err;
  logic [DW-1:0]   o_wb_data;
  logic            o_s_cyc, o_s_stb, o_s_we;
  logic [AW-1:0]   o_s_addr;
  logic [DW-1:0]   o_s_data;
  logic [DW/8-1:0] o_s_sel;
  logic            i_s_stall, i_s_ack, i_s_err;
  logic [DW-1:0]   i_s_data;
  logic            o_timeout;
  logic [15:0]     o_abort_count;
  logic [LGO:0]    o_outstanding;

  always #5 i_clk = ~i_clk;

  wbu_busguard #(.AW(AW), .DW(DW), .LGWATCHDOG(LGW), .LGOUTST(LGO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_timeout(i_timeout),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
    .o_wb_data(o_wb_data),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
    .o_s_addr(o_s_addr), .o_s_data(o_s_data), .o_s_sel(o_s_sel),
    .i_s_stall(i_s_stall), .i_s_ack(i_s_ack), .i_s_err(i_s_err),
    .i_s_data(i_s_data),
    .o_timeout(o_timeout), .o_abort_count(o_abort_count),
    .o_outstanding(o_outstanding)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: transaction-level view of the guard.
  bit m_busy, m_abort, m_drain;
  int m_out, m_timer, m_cnt;
  int n_acks, n_tmo, max_out;

  // One clock cycle: compare at the falling edge, advance the model, release after the rising edge.
  task automatic step();
    bit normal, full, e_stb, acc, resp, fire;
    int tmo, prev_out;
    @(negedge i_clk);
    normal = !m_abort && !m_drain;
    full   = (m_out == CAP);
    e_stb  = normal && i_wb_stb && !full && !i_reset;
    check("s_cyc",  64'(o_s_cyc),    64'(normal && i_wb_cyc && !i_reset));
    check("s_stb",  64'(o_s_stb),    64'(e_stb));
    check("stall",  64'(o_wb_stall), 64'(normal ? (i_s_stall || full) : 1'b1));
    check("ack",    64'(o_wb_ack),   64'(normal && !i_reset && i_s_ack && !i_s_err));
    check("err",    64'(o_wb_err),   64'(!i_reset && (m_abort || (normal && i_s_err))));
    check("tmo",    64'(o_timeout),  64'(m_abort));
    check("outst",  64'(o_outstanding), 64'(m_out));
    check("abcnt",  64'(o_abort_count), 64'(m_cnt));
    if (normal) begin
      check("fwd_adr", 64'(o_s_addr), 64'(i_wb_addr));
      check("fwd_dat", 64'({o_s_we, o_s_sel, o_s_data}), 64'({i_wb_we, i_wb_sel, i_wb_data}));
      check("rsp_dat", 64'(o_wb_data), 64'(i_s_data));
    end
    if (o_wb_ack) n_acks++;
    if (o_timeout) n_tmo++;
    if (int'(o_outstanding) > max_out) max_out = int'(o_outstanding);

    acc  = e_stb && !i_s_stall;
    resp = i_s_ack || i_s_err;
    tmo  = int'(i_timeout);
    if (i_reset) begin
      m_busy = 0; m_abort = 0; m_drain = 0; m_out = 0; m_timer = 0; m_cnt = 0;
    end else if (m_abort) begin
      m_abort = 0; m_drain = 1; m_out = 0; m_timer = 0;
    end else if (m_drain) begin
      m_drain = i_wb_cyc; m_out = 0; m_timer = 0;
    end else begin
      fire = m_busy && i_wb_cyc && tmo != 0 && m_timer == tmo - 1 && !acc && !resp;
      prev_out = m_out;
      if (!i_wb_cyc || fire) m_out = 0;
      else if (acc && !resp) m_out = m_out + 1;
      else if (!acc && resp && m_out > 0) m_out = m_out - 1;
      if (!m_busy || !i_wb_cyc || acc || resp || fire) m_timer = 0;
      else if (tmo != 0 && (prev_out != 0 || i_wb_stb)) m_timer++;
      if (fire) begin
        m_abort = 1;
        m_busy  = 0;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_busy = i_wb_cyc;
      end
    end
    @(posedge i_clk);
    #1;
    i_wb_addr = AW'($urandom);
    i_wb_data = DW'($urandom);
    i_wb_sel  = (DW/8)'($urandom);
    i_wb_we   = 1'($urandom);
    i_s_data  = DW'($urandom);
  endtask

  task automatic drv(input bit cyc, input bit stb, input bit st, input bit ack, input bit err);
    i_wb_cyc = cyc; i_wb_stb = stb; i_s_stall = st; i_s_ack = ack; i_s_err = err;
    step();
  endtask

  initial begin
    i_reset = 1'b1; i_timeout = LGW'(100);
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_s_stall = 0; i_s_ack = 0; i_s_err = 0;
    i_wb_addr = '0; i_wb_data = '0; i_wb_sel = '0; i_s_data = '0;
    m_busy = 0; m_abort = 0; m_drain = 0; m_out = 0; m_timer = 0; m_cnt = 0;
    n_acks = 0; n_tmo = 0; max_out = 0;

    repeat (3) step();
    check("rst_outst", 64'(o_outstanding), 64'(0));
    check("rst_abcnt", 64'(o_abort_count), 64'(0));
    i_reset = 1'b0;
    drv(0, 0, 1, 0, 0);
    check("idle_stall", 64'(o_wb_stall), 64'(1));

    // Single read, slave acks three cycles after accept.
    n_acks = 0; n_tmo = 0; max_out = 0;
    drv(1, 1, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    drv(1, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    check("rd_acks", 64'(n_acks), 64'(1));
    check("rd_maxout", 64'(max_out), 64'(1));
    check("rd_notmo", 64'(n_tmo), 64'(0));

    // Hung slave, timeout 8.
    i_timeout = LGW'(8);
    drv(1, 1, 0, 0, 0);
    repeat (7) drv(1, 0, 0, 0, 0);
    check("hang_pre", 64'(o_timeout), 64'(0));
    drv(1, 0, 0, 0, 0);
    check("hang_tmo", 64'(o_timeout), 64'(1));
    check("hang_err", 64'(o_wb_err), 64'(1));
    check("hang_cyc", 64'(o_s_cyc), 64'(0));
    repeat (4) drv(1, 0, 0, 0, 0);
    check("hang_stall", 64'(o_wb_stall), 64'(1));
    check("hang_abcnt", 64'(o_abort_count), 64'(1));
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    check("hang_idle", 64'(o_wb_stall), 64'(0));

    // Burst of 6 against a 4-deep limit, slave acks late.
    i_timeout = '0;
    n_acks = 0; max_out = 0;
    begin
      int left = 6;
      for (int c = 0; c < 80 && (left > 0 || m_out > 0); c++) begin
        bit stb, ack;
        stb = (left > 0);
        ack = (m_out == CAP || left == 0) && m_out > 0;
        if (stb && m_out != CAP) left--;
        drv(1, stb, 0, ack, 0);
        if (m_out == CAP) check("burst_stall", 64'(o_wb_stall), 64'(1));
      end
    end
    check("burst_acks", 64'(n_acks), 64'(6));
    check("burst_max", 64'(max_out), 64'(CAP));
    check("burst_done", 64'(o_outstanding), 64'(0));
    drv(0, 0, 0, 0, 0);

    // Ack lands on the expiry cycle, then timer restarts from that ack.
    i_timeout = LGW'(5);
    n_acks = 0;
    drv(1, 1, 0, 0, 0);
    repeat (4) drv(1, 0, 0, 0, 0);
    drv(1, 0, 0, 1, 0);
    check("race_notmo", 64'(o_timeout), 64'(0));
    check("race_acks", 64'(n_acks), 64'(1));
    drv(1, 1, 0, 0, 0);
    repeat (4) drv(1, 0, 0, 0, 0);
    check("race_pre", 64'(o_timeout), 64'(0));
    drv(1, 0, 0, 0, 0);
    check("race_restart", 64'(o_timeout), 64'(1));
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);

    // Watchdog disabled over a long hang, then enabled.
    i_timeout = '0;
    drv(1, 1, 0, 0, 0);
    repeat (2000) drv(1, 0, 0, 0, 0);
    check("dis_notmo", 64'(o_timeout), 64'(0));
    i_timeout = LGW'(10);
    repeat (9) drv(1, 0, 0, 0, 0);
    check("en_pre", 64'(o_timeout), 64'(0));
    drv(1, 0, 0, 0, 0);
    check("en_tmo", 64'(o_timeout), 64'(1));

    // Late acks during abort/drain are swallowed.
    drv(1, 0, 0, 1, 0);
    drv(1, 0, 0, 1, 0);
    check("drain_ack", 64'(o_wb_ack), 64'(0));
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);

    // Reset with two requests outstanding.
    i_timeout = LGW'(50);
    drv(1, 1, 0, 0, 0);
    drv(1, 1, 0, 0, 0);
    check("rb_two", 64'(o_outstanding), 64'(2));
    i_reset = 1'b1;
    drv(1, 0, 0, 1, 0);
    i_reset = 1'b0;
    check("rb_outst", 64'(o_outstanding), 64'(0));
    drv(0, 0, 0, 0, 0);

    // Randomized traffic with varying slave responsiveness.
    for (int seg = 0; seg < 15; seg++) begin
      int ackp;
      ackp = (seg % 3 == 0) ? 40 : ((seg % 3 == 1) ? 8 : 3);
      for (int c = 0; c < 200; c++) begin
        if ($urandom % 20 == 0) i_wb_cyc = ~i_wb_cyc;
        i_wb_stb  = i_wb_cyc && ($urandom % 2 == 0);
        i_s_stall = ($urandom % 4 == 0);
        i_s_ack   = ($urandom % ackp == 0);
        i_s_err   = ($urandom % (ackp * 4) == 0);
        i_reset   = ($urandom % 300 == 0);
        if ($urandom % 80 == 0) i_timeout = LGW'($urandom_range(0, 12));
        step();
      end
    end
    i_reset = 1'b0;
    drv(0, 0, 0, 0, 0);
    check("final_abcnt", 64'(o_abort_count), 64'(m_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wbu_busguard.md
WBU_BUSGUARD -- requirements
Module: wbu_busguard

Interface
REQ-001 Parameters SHALL be: AW, default 30, word address width; DW, default 32, data width (multiple of 8); LGWATCHDOG, default 19, timer width; LGOUTST, default 4, log2 of outstanding-request capacity.
REQ-002 i_clk  in  1  clock; i_reset  in  1  reset, synchronous, active-high.
REQ-003 i_timeout  in  LGWATCHDOG  runtime timeout in cycles; 0 disables the watchdog.
REQ-004 i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  upstream master controls.
REQ-005 i_wb_addr  in  AW; i_wb_data  in  DW; i_wb_sel  in  DW/8  upstream request fields.
REQ-006 o_wb_stall, o_wb_ack, o_wb_err  out  1 each; o_wb_data  out  DW  upstream responses.
REQ-007 o_s_cyc, o_s_stb, o_s_we  out  1 each; o_s_addr  out  AW; o_s_data  out  DW; o_s_sel  out  DW/8  downstream request.
REQ-008 i_s_stall, i_s_ack, i_s_err  in  1 each; i_s_data  in  DW  downstream responses.
REQ-009 o_timeout  out  1  one-cycle pulse on each watchdog abort; o_abort_count  out  16  saturating abort count; o_outstanding  out  LGOUTST+1  current outstanding count.

Function
REQ-010 State machine SHALL have states IDLE, BUSY, ABORT, DRAIN.
REQ-011 IDLE->BUSY when i_wb_cyc=1; BUSY->IDLE when i_wb_cyc=0; BUSY->ABORT on timeout (REQ-015); ABORT->DRAIN after exactly one cycle; DRAIN->IDLE when i_wb_cyc=0.
REQ-012 In IDLE/BUSY: o_s_cyc=i_wb_cyc, o_s_stb=i_wb_stb && !full, address/data/sel/we combinationally forwarded, o_wb_stall=i_s_stall || full, o_wb_ack=i_s_ack, o_wb_err=i_s_err, o_wb_data=i_s_data; zero added latency.
REQ-013 Accepted request = o_s_stb && !i_s_stall; response = i_s_ack || i_s_err; o_outstanding SHALL increment on accept only, decrement on response only, be unchanged on both or neither, and clear to 0 on the cycle after i_wb_cyc=0.
REQ-014 full SHALL be o_outstanding == 2^LGOUTST; a response arriving while full SHALL not unblock o_s_stb until the next cycle.
REQ-015 Timer SHALL reset to 0 on any accept, any response, i_wb_cyc=0, or state other than BUSY; otherwise increment while in BUSY with (o_outstanding!=0 || i_wb_stb); timeout SHALL fire when i_timeout!=0 and timer==i_timeout-1 at a clock edge.
REQ-016 A response on the same cycle the timer would fire SHALL win: timer resets, no abort.
REQ-017 In ABORT: o_s_cyc=o_s_stb=0, o_wb_err=1, o_wb_ack=0, o_wb_stall=1, o_timeout=1.
REQ-018 In DRAIN: o_s_cyc=o_s_stb=0, o_wb_stall=1, o_wb_ack=o_wb_err=0; late i_s_ack/i_s_err SHALL be discarded; o_outstanding held at 0.
REQ-019 o_abort_count SHALL increment by 1 per abort and saturate at 16'hFFFF.
REQ-020 A change of i_timeout SHALL take effect on the next comparison; it SHALL NOT reset the timer.
REQ-021 o_wb_ack and o_wb_err SHALL never both be 1; if i_s_ack && i_s_err, o_wb_err=1, o_wb_ack=0.

Reset
REQ-022 On i_reset: state=IDLE, timer=0, o_outstanding=0, o_abort_count=0, o_timeout=0.
REQ-023 Reset mid-operation SHALL drop o_s_cyc/o_s_stb in the same cycle i_reset is sampled high through the next edge and return IDLE; no err issued upstream.
REQ-024 All outputs after reset with i_wb_cyc=0: o_s_cyc=0, o_s_stb=0, o_wb_ack=0, o_wb_err=0, o_wb_stall=i_s_stall.

Verification
REQ-025 Single read, i_timeout=100, slave acks 3 cycles after accept -> one o_wb_ack, o_outstanding 0->1->0, no o_timeout.
REQ-026 i_timeout=8, slave never acks after accept -> o_wb_err and o_timeout high exactly 8 cycles after accept, o_s_cyc low from then, o_abort_count=1, stall held until i_wb_cyc drops.
REQ-027 LGOUTST=2, burst of 6 stbs with slave never stalling and acking late -> o_wb_stall high after 4 accepts, o_outstanding max 4, all 6 acked.
REQ-028 Ack arrives in the cycle timeout would fire (i_timeout=5) -> o_wb_ack=1, no abort, timer restarts.
REQ-029 i_timeout=0, hung slave 100000 cycles -> no abort; then i_timeout=10 -> abort 10 cycles later.
REQ-030 Slave acks during DRAIN, and i_reset asserted in BUSY with 2 outstanding -> no upstream ack passed; after reset o_outstanding=0, state IDLE.
